samus_controller: RTL and testbench
===================================

// Module: samus_controller
// PURPOSE
//  Player-motion stage directly upstream of sprite_mapper. Consumes the USB keycode word exported
//  by the NIOS system and the VGA vertical sync. Once per video frame it updates Samus' position,
//  facing, animation frame and fire request, and drives the samus_* and bullet-spawn inputs of
//  sprite_mapper.
// PARAMETERS
//  START_X        304  reset x position (pixels, sprite top-left)
//  GROUND_Y       400  floor y position; y never exceeds it
//  X_MIN          0    left clamp for x
//  X_MAX          608  right clamp for x (640 - 32 px sprite width)
//  X_SPEED        2    px per frame while running
//  JUMP_V0        12   initial upward velocity, px/frame
//  GRAVITY        1    px/frame^2 added to vy each airborne frame
//  MAX_FALL       12   clamp for downward vy
//  ANIM_DIV       6    frames per run-animation step
//  FIRE_COOLDOWN  8    frames after a shot during which fire presses are ignored
// PORTS
//  clk           in   1   50 MHz system clock (CLOCK_50)
//  reset_n       in   1   asynchronous, active-low reset
//  vsync         in   1   VGA_VS, active-low, asynchronous to clk domain logic
//  keycode       in   16  two HID usage codes: [7:0] slot 0, [15:8] slot 1; 0x00 = no key
//  frame_tick    out  1   1-clk pulse, once per frame
//  samus_x       out  10  sprite x, unsigned
//  samus_y       out  10  sprite y, unsigned
//  samus_sprite  out  3   0 = stand, 1-3 = run frames, 4 = jump-rise, 5 = fall
//  samus_facing  out  1   0 = right, 1 = left
//  fire          out  1   1-clk pulse requesting a bullet spawn at current x/y/facing
// BEHAVIOUR
//  Reset values: x = START_X, y = GROUND_Y, sprite = 0, facing = 0, fire = 0, frame_tick = 0.
//  Internal reset values: vy = 0, state = STAND, anim/cooldown counters = 0, previous-key flags = 0.
//  Both vsync synchroniser flops reset to 1, so neither reset nor its release produces a tick.
//  Frame tick:
//   - vsync passes through a 2-flop synchroniser.
//   - A falling edge of the synchronised signal asserts frame_tick on the next clk.
//   - All outputs below update only on the frame_tick cycle, registered and visible the cycle after.
//  Key decode: a key is pressed if either slot equals its code:
//   - L = 0x04, R = 0x07, JUMP = 0x1A, FIRE = 0x2C.
//   - Jump and fire act on press edges only (pressed this frame, not last frame).
//  Horizontal motion:
//   - L only: x -= X_SPEED, facing = 1. R only: x += X_SPEED, facing = 0.
//   - L and R together, or neither: no move, facing held.
//   - Compute in 11-bit signed and saturate to [X_MIN, X_MAX]; no wrap-around.
//   - Horizontal motion applies in every state, including in the air.
//  FSM (state_t):
//   - STAND <-> RUN on ground, per horizontal motion; a saturated, blocked push still counts as RUN.
//   - STAND/RUN + jump edge: go to AIR, vy = -JUMP_V0.
//   - Jump edge while in AIR: ignored. Holding JUMP on landing does not re-jump.
//   - AIR, each tick:
//       if y + vy >= GROUND_Y: y = GROUND_Y, vy = 0, go to STAND/RUN.
//       else: y += vy, then vy = min(vy + GRAVITY, MAX_FALL).
//   - vy is 6-bit signed.
//  Sprite:
//   - STAND = 0. AIR = 4 if the new vy < 0, else 5.
//   - RUN cycles 1 -> 2 -> 3 -> 1, advancing every ANIM_DIV ticks; it enters at 1 with the
//     counter cleared. Leaving RUN clears the counter.
//  Fire:
//   - A fire edge with cooldown == 0 asserts fire for exactly the clk after frame_tick and loads
//     cooldown = FIRE_COOLDOWN.
//   - Cooldown decrements once per tick.
//   - Presses during cooldown are dropped, not queued.
//  Keycode changes between ticks are not observed; only the value on the tick cycle matters.
//  Reset mid-frame or mid-jump returns immediately and asynchronously to the reset values.
// STRUCTURE
//  samus_pkg: state_t enum {STAND, RUN, AIR}.
//  samus_pkg: keycode localparams KEY_L/KEY_R/KEY_JUMP/KEY_FIRE.
//  samus_pkg: sprite index constants SPR_STAND, SPR_RUN0, SPR_RISE, SPR_FALL.
//  Sub-module frame_tick_gen: vsync synchroniser plus falling-edge pulse (clk, reset_n, vsync -> tick).
//  Remainder (FSM, datapath) stays in one always_ff with combinational next-state.
// TESTING
//  1 Reset with vsync held high for 100 clk -> x = 304, y = 400, sprite = 0, frame_tick never asserted.
//  2 keycode = 0x0007 for 10 frames -> x = 324, facing = 0, sprite 1 for frames 1-6, then 2.
//    Hold 200 frames -> x saturates at 608.
//  3 keycode = 0x001A for 1 frame, then 0:
//    - y = 388, 377, ...; peak y = 322 at tick 12.
//    - sprite 4 on ticks 1-11, 5 on ticks 12-24.
//    - Lands with y = 400, sprite 0 at tick 25.
//  4 keycode = 0x1A04 held -> one jump only; x -= 2 every frame in the air; no re-jump after landing at tick 25.
//  5 FIRE (0x002C) pressed at frames 0, 2 (released between) and 9 -> fire pulses at frames 0 and 9 only.
//    Each pulse is 1 clk wide, one clk after frame_tick.
//  6 keycode = 0x0704 -> x unchanged, sprite 0, facing held.
//    Assert reset_n low mid-jump -> outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/samus_pkg.sv
// Shared types and constants for the Samus player-motion stage.
package samus_pkg;

  typedef enum logic [1:0] {STAND, RUN, AIR} state_t;

  localparam logic [7:0] KEY_L    = 8'h04;
  localparam logic [7:0] KEY_R    = 8'h07;
  localparam logic [7:0] KEY_JUMP = 8'h1A;
  localparam logic [7:0] KEY_FIRE = 8'h2C;

  localparam logic [2:0] SPR_STAND = 3'd0;
  localparam logic [2:0] SPR_RUN0  = 3'd1;
  localparam logic [2:0] SPR_RUN2  = 3'd3;
  localparam logic [2:0] SPR_RISE  = 3'd4;
  localparam logic [2:0] SPR_FALL  = 3'd5;

  // A key counts as held if either HID slot carries its usage code.
  function automatic logic key_hit(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronises VGA vsync into the clk domain and emits a 1-clk pulse per falling edge.
module frame_tick_gen (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync,
  output logic tick
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       tick_q;

  // All history flops reset high so reset and its release never look like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], vsync};
      prev_q <= sync_q[1];
      tick_q <= prev_q & ~sync_q[1];
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/samus_controller.sv
// Per-frame Samus motion: position, facing, animation frame and bullet-fire request.
module samus_controller
  import samus_pkg::*;
#(
  parameter int unsigned START_X       = 304,
  parameter int unsigned GROUND_Y      = 400,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 608,
  parameter int unsigned X_SPEED       = 2,
  parameter int unsigned JUMP_V0       = 12,
  parameter int unsigned GRAVITY       = 1,
  parameter int unsigned MAX_FALL      = 12,
  parameter int unsigned ANIM_DIV      = 6,
  parameter int unsigned FIRE_COOLDOWN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [15:0] keycode,
  output logic        frame_tick,
  output logic [9:0]  samus_x,
  output logic [9:0]  samus_y,
  output logic [2:0]  samus_sprite,
  output logic        samus_facing,
  output logic        fire
);

  localparam int unsigned AnimW = $clog2(ANIM_DIV);
  localparam int unsigned CoolW = $clog2(FIRE_COOLDOWN + 1);

  localparam logic signed [10:0] XStep  = 11'(X_SPEED);
  localparam logic signed [10:0] XMinS  = 11'(X_MIN);
  localparam logic signed [10:0] XMaxS  = 11'(X_MAX);
  localparam logic signed [11:0] GroundS = 12'(GROUND_Y);
  localparam logic signed [5:0]  JumpV0 = 6'(JUMP_V0);
  localparam logic signed [5:0]  Grav   = 6'(GRAVITY);
  localparam logic signed [5:0]  MaxFall = 6'(MAX_FALL);
  localparam logic [AnimW-1:0]   AnimLast = AnimW'(ANIM_DIV - 1);
  localparam logic [CoolW-1:0]   CoolLoad = CoolW'(FIRE_COOLDOWN);

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [5:0] vy_q, vy_d;
  logic [2:0]        sprite_q, sprite_d;
  logic              facing_q, facing_d;
  logic              fire_q;
  logic [AnimW-1:0]  anim_q, anim_d;
  logic [CoolW-1:0]  cool_q, cool_d;
  logic              jump_prev_q, fire_prev_q;

  logic              left, right, jump, fire_key, jump_edge, fire_edge, moving, air, fire_go;
  logic signed [10:0] x_move;
  logic signed [5:0]  vy_cur, vy_inc, vy_fall;
  logic signed [11:0] y_sum;

  frame_tick_gen u_frame_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .tick    (frame_tick)
  );

  always_comb begin
    left      = key_hit(keycode, KEY_L);
    right     = key_hit(keycode, KEY_R);
    jump      = key_hit(keycode, KEY_JUMP);
    fire_key  = key_hit(keycode, KEY_FIRE);
    jump_edge = jump & ~jump_prev_q;
    fire_edge = fire_key & ~fire_prev_q;
    moving    = left ^ right;

    x_move   = $signed({1'b0, x_q});
    facing_d = facing_q;
    if (left && !right) begin
      x_move   = x_move - XStep;
      facing_d = 1'b1;
    end else if (right && !left) begin
      x_move   = x_move + XStep;
      facing_d = 1'b0;
    end
    if (x_move < XMinS)      x_d = 10'(X_MIN);
    else if (x_move > XMaxS) x_d = 10'(X_MAX);
    else                     x_d = x_move[9:0];

    // A jump edge launches and takes its first airborne step on the same tick.
    air     = (state_q == AIR) || jump_edge;
    vy_cur  = (state_q != AIR && jump_edge) ? -JumpV0 : vy_q;
    y_sum   = $signed({2'b00, y_q}) + $signed({{6{vy_cur[5]}}, vy_cur});
    vy_inc  = vy_cur + Grav;
    vy_fall = (vy_inc > MaxFall) ? MaxFall : vy_inc;

    state_d  = state_q;
    y_d      = y_q;
    vy_d     = vy_q;
    sprite_d = sprite_q;
    anim_d   = anim_q;
    if (air) begin
      anim_d = '0;
      if (y_sum >= GroundS) begin
        y_d      = 10'(GROUND_Y);
        vy_d     = '0;
        state_d  = moving ? RUN : STAND;
        sprite_d = moving ? SPR_RUN0 : SPR_STAND;
      end else begin
        y_d      = y_sum[9:0];
        vy_d     = vy_fall;
        state_d  = AIR;
        sprite_d = vy_fall[5] ? SPR_RISE : SPR_FALL;
      end
    end else if (moving) begin
      state_d = RUN;
      if (state_q != RUN) begin
        sprite_d = SPR_RUN0;
        anim_d   = '0;
      end else if (anim_q == AnimLast) begin
        anim_d   = '0;
        sprite_d = (sprite_q == SPR_RUN2) ? SPR_RUN0 : sprite_q + 3'd1;
      end else begin
        anim_d = anim_q + 1'b1;
      end
    end else begin
      state_d  = STAND;
      sprite_d = SPR_STAND;
      anim_d   = '0;
    end

    fire_go = fire_edge && (cool_q == '0);
    if (fire_go)            cool_d = CoolLoad;
    else if (cool_q != '0)  cool_d = cool_q - 1'b1;
    else                    cool_d = cool_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STAND;
      x_q         <= 10'(START_X);
      y_q         <= 10'(GROUND_Y);
      vy_q        <= '0;
      sprite_q    <= SPR_STAND;
      facing_q    <= 1'b0;
      fire_q      <= 1'b0;
      anim_q      <= '0;
      cool_q      <= '0;
      jump_prev_q <= 1'b0;
      fire_prev_q <= 1'b0;
    end else begin
      fire_q <= frame_tick & fire_go;
      if (frame_tick) begin
        state_q     <= state_d;
        x_q         <= x_d;
        y_q         <= y_d;
        vy_q        <= vy_d;
        sprite_q    <= sprite_d;
        facing_q    <= facing_d;
        anim_q      <= anim_d;
        cool_q      <= cool_d;
        jump_prev_q <= jump;
        fire_prev_q <= fire_key;
      end
    end
  end

  assign samus_x      = x_q;
  assign samus_y      = y_q;
  assign samus_sprite = sprite_q;
  assign samus_facing = facing_q;
  assign fire         = fire_q;

endmodule

// File: tb/tb_samus_controller.sv
// Directed bench for samus_controller: frames are driven through vsync and checked after each tick.
module tb_samus_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic [15:0] keycode;
  logic        frame_tick;
  logic [9:0]  samus_x, samus_y;
  logic [2:0]  samus_sprite;
  logic        samus_facing, fire;

  int tests = 0;
  int fails = 0;
  int tick_cnt = 0;
  logic fire_seen, fire_late, tick_seen, tick_after;

  samus_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .keycode      (keycode),
    .frame_tick   (frame_tick),
    .samus_x      (samus_x),
    .samus_y      (samus_y),
    .samus_sprite (samus_sprite),
    .samus_facing (samus_facing),
    .fire         (fire)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_tick) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One video frame: vsync low until the tick appears (bounded), sample the cycle after it.
  task automatic frame(input logic [15:0] kc);
    @(negedge clk);
    keycode   = kc;
    vsync     = 1'b0;
    tick_seen = 1'b0;
    for (int i = 0; i < 10 && !tick_seen; i++) begin
      @(negedge clk);
      tick_seen = frame_tick;
    end
    check("frame_tick_seen", 16'(tick_seen), 16'd1);
    @(negedge clk);
    fire_seen  = fire;
    tick_after = frame_tick;
    @(negedge clk);
    fire_late = fire;
    vsync     = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    vsync   = 1'b1;
    keycode = 16'h0000;

    // 1: reset with vsync high, no ticks
    repeat (100) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("reset_x", 16'(samus_x), 16'd304);
    check("reset_y", 16'(samus_y), 16'd400);
    check("reset_sprite", 16'(samus_sprite), 16'd0);
    check("reset_facing", 16'(samus_facing), 16'd0);
    check("reset_fire", 16'(fire), 16'd0);
    check("reset_no_tick", 16'(tick_cnt), 16'd0);

    // 2: run right, animation and saturation
    for (int i = 1; i <= 10; i++) begin
      frame(16'h0007);
      check("run_sprite", 16'(samus_sprite), (i <= 6) ? 16'd1 : 16'd2);
      check("tick_width", 16'(tick_after), 16'd0);
    end
    check("run_x", 16'(samus_x), 16'd324);
    check("run_facing", 16'(samus_facing), 16'd0);
    repeat (200) frame(16'h0007);
    check("run_sat_x", 16'(samus_x), 16'd608);
    frame(16'h0000);
    check("stop_sprite", 16'(samus_sprite), 16'd0);
    check("stop_x", 16'(samus_x), 16'd608);

    // 3: single jump press
    for (int t = 1; t <= 25; t++) begin
      frame((t == 1) ? 16'h001A : 16'h0000);
      check("jump_sprite", 16'(samus_sprite),
            (t <= 11) ? 16'd4 : (t <= 24) ? 16'd5 : 16'd0);
      if (t == 1)  check("jump_y1", 16'(samus_y), 16'd388);
      if (t == 2)  check("jump_y2", 16'(samus_y), 16'd377);
      if (t == 12) check("jump_peak", 16'(samus_y), 16'd322);
      if (t == 24) check("jump_y24", 16'(samus_y), 16'd388);
    end
    check("land_y", 16'(samus_y), 16'd400);
    check("jump_x", 16'(samus_x), 16'd608);

    // 4: jump + left held, single jump, drift left
    for (int t = 1; t <= 26; t++) begin
      frame(16'h1A04);
      check("hold_x", 16'(samus_x), 16'(608 - 2 * t));
      if (t == 12) check("hold_peak", 16'(samus_y), 16'd322);
    end
    check("hold_y", 16'(samus_y), 16'd400);
    check("hold_sprite", 16'(samus_sprite), 16'd1);
    check("hold_facing", 16'(samus_facing), 16'd1);
    frame(16'h0000);

    // 5: fire with cooldown
    for (int f = 0; f <= 9; f++) begin
      frame((f == 0 || f == 2 || f == 9) ? 16'h002C : 16'h0000);
      check("fire_pulse", 16'(fire_seen), (f == 0 || f == 9) ? 16'd1 : 16'd0);
      check("fire_width", 16'(fire_late), 16'd0);
    end

    // 6: L+R together, then reset mid-jump
    frame(16'h0704);
    check("lr_x", 16'(samus_x), 16'd556);
    check("lr_sprite", 16'(samus_sprite), 16'd0);
    check("lr_facing", 16'(samus_facing), 16'd1);
    frame(16'h001A);
    check("mid_jump_y", 16'(samus_y), 16'd388);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_x", 16'(samus_x), 16'd304);
    check("rst_y", 16'(samus_y), 16'd400);
    check("rst_sprite", 16'(samus_sprite), 16'd0);
    check("rst_facing", 16'(samus_facing), 16'd0);
    check("rst_fire", 16'(fire), 16'd0);
    check("rst_tick", 16'(frame_tick), 16'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
